// File: rtl/serial_frame_sender.sv
// Framed serial bit-stream source: idle-high line, start bit, LEN_W-bit length
// MSB-first, then N payload bits MSB-first, advanced by a step strobe.
module serial_frame_sender #(
   parameter int LEN_W  = 4,
   parameter int DATA_W = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [DATA_W-1:0] data,
   output logic              ser_out,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  remaining
);

   localparam int IDX_W = (LEN_W > 1) ? $clog2(LEN_W) : 1;

   typedef enum logic [1:0] {
      IDLE,
      START,
      LEN,
      DATA
   } state_t;

   state_t             state, stateNext;
   logic [LEN_W-1:0]   lenQ, lenNext;
   logic [DATA_W-1:0]  dataQ, dataNext;
   logic [IDX_W-1:0]   idxQ, idxNext;
   logic [LEN_W-1:0]   remQ, remNext;
   logic               serQ, serNext;
   logic               busyQ, busyNext;
   logic               doneQ, doneNext;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         lenQ  <= '0;
         dataQ <= '0;
         idxQ  <= '0;
         remQ  <= '0;
         serQ  <= 1'b1;
         busyQ <= 1'b0;
         doneQ <= 1'b0;
      end else begin
         state <= stateNext;
         lenQ  <= lenNext;
         dataQ <= dataNext;
         idxQ  <= idxNext;
         remQ  <= remNext;
         serQ  <= serNext;
         busyQ <= busyNext;
         doneQ <= doneNext;
      end
   end

   // Every output is the registered image of the next-state values below,
   // so the line changes exactly on the edge that releases the previous bit.
   always_comb begin
      stateNext = state;
      lenNext   = lenQ;
      dataNext  = dataQ;
      idxNext   = idxQ;
      remNext   = remQ;
      serNext   = serQ;
      busyNext  = busyQ;
      doneNext  = 1'b0;

      case (state)
         IDLE: begin
            serNext  = 1'b1;
            busyNext = 1'b0;
            remNext  = '0;
            if (start) begin
               lenNext   = len;
               dataNext  = data;
               stateNext = START;
               serNext   = 1'b0;
               busyNext  = 1'b1;
            end
         end

         START: begin
            if (step) begin
               stateNext = LEN;
               idxNext   = IDX_W'(LEN_W - 1);
               serNext   = lenQ[LEN_W-1];
            end
         end

         LEN: begin
            if (step) begin
               if (idxQ == '0) begin
                  if (lenQ != '0) begin
                     stateNext = DATA;
                     remNext   = lenQ;
                     serNext   = dataQ[lenQ - LEN_W'(1)];
                  end else begin
                     stateNext = IDLE;
                     serNext   = 1'b1;
                     busyNext  = 1'b0;
                     doneNext  = 1'b1;
                  end
               end else begin
                  idxNext = idxQ - IDX_W'(1);
                  serNext = lenQ[idxQ - IDX_W'(1)];
               end
            end
         end

         DATA: begin
            if (step) begin
               if (remQ == LEN_W'(1)) begin
                  stateNext = IDLE;
                  serNext   = 1'b1;
                  busyNext  = 1'b0;
                  remNext   = '0;
                  doneNext  = 1'b1;
               end else begin
                  remNext = remQ - LEN_W'(1);
                  serNext = dataQ[remQ - LEN_W'(2)];
               end
            end
         end

         default: begin
            stateNext = IDLE;
            serNext   = 1'b1;
            busyNext  = 1'b0;
            remNext   = '0;
         end
      endcase
   end

   assign ser_out   = serQ;
   assign busy      = busyQ;
   assign done      = doneQ;
   assign remaining = remQ;

endmodule

// File: tb/tb_serial_frame_sender.sv
// Directed bench for serial_frame_sender: nominal, zero length, stall,
// ignore-while-busy, back-to-back and asynchronous reset mid-frame.
module tb_serial_frame_sender;

   logic        clk = 1'b0;
   logic        rst;
   logic        step;
   logic        start;
   logic [3:0]  len;
   logic [14:0] data;
   logic        ser_out;
   logic        busy;
   logic        done;
   logic [3:0]  remaining;

   int unsigned checks = 0;
   int unsigned passes = 0;

   serial_frame_sender #(.LEN_W(4), .DATA_W(15)) dut (
      .clk       (clk),
      .rst       (rst),
      .step      (step),
      .start     (start),
      .len       (len),
      .data      (data),
      .ser_out   (ser_out),
      .busy      (busy),
      .done      (done),
      .remaining (remaining)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // expSer holds the hand-computed line sequence, first bit in bit nb-1.
   task automatic runFrame(input string tag, input logic [3:0] l, input logic [14:0] d,
                           input logic [19:0] expSer, input int nb);
      len   = l;
      data  = d;
      start = 1'b1;
      step  = 1'b1;
      for (int i = 0; i < nb; i++) begin
         tick();
         start = 1'b0;
         checkVal($sformatf("%s ser[%0d]", tag, i), 32'(ser_out), 32'(expSer[nb-1-i]));
         checkVal($sformatf("%s busy[%0d]", tag, i), 32'(busy), 32'd1);
         checkVal($sformatf("%s done[%0d]", tag, i), 32'(done), 32'd0);
         checkVal($sformatf("%s rem[%0d]", tag, i), 32'(remaining),
                  (i >= 5) ? 32'(nb - i) : 32'd0);
      end
      tick();
      checkVal({tag, " idle ser"}, 32'(ser_out), 32'd1);
      checkVal({tag, " idle busy"}, 32'(busy), 32'd0);
      checkVal({tag, " done pulse"}, 32'(done), 32'd1);
      checkVal({tag, " idle rem"}, 32'(remaining), 32'd0);
      tick();
      checkVal({tag, " done cleared"}, 32'(done), 32'd0);
      checkVal({tag, " stays idle"}, 32'(ser_out), 32'd1);
   endtask

   initial begin
      logic [8:0] ignSer;
      logic [6:0] stallSer;
      logic [6:0] b2bSer;

      rst   = 1'b1;
      step  = 1'b0;
      start = 1'b0;
      len   = '0;
      data  = '0;
      #2 rst = 1'b0;
      #1;
      checkVal("reset ser", 32'(ser_out), 32'd1);
      checkVal("reset busy", 32'(busy), 32'd0);
      checkVal("reset done", 32'(done), 32'd0);
      checkVal("reset rem", 32'(remaining), 32'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      checkVal("post-reset idle", 32'(ser_out), 32'd1);

      // len=3 (0011), data ..101 with ones above bit 2
      runFrame("nominal", 4'd3, 15'h7FFD, 20'b0_0011_101, 8);
      // len=0: start plus four zero length bits
      runFrame("zero", 4'd0, 15'h7FFF, 20'b0_0000, 5);

      // Stall: step high on every third edge after the accept edge
      stallSer = 7'b0_0010_10;
      len   = 4'd2;
      data  = 15'h7FFE;
      start = 1'b1;
      step  = 1'b0;
      for (int k = 0; k <= 22; k++) begin
         tick();
         start = 1'b0;
         if (k < 21) begin
            checkVal($sformatf("stall ser[%0d]", k), 32'(ser_out), 32'(stallSer[6 - k/3]));
            checkVal($sformatf("stall busy[%0d]", k), 32'(busy), 32'd1);
            checkVal($sformatf("stall done[%0d]", k), 32'(done), 32'd0);
            checkVal($sformatf("stall rem[%0d]", k), 32'(remaining),
                     (k >= 18) ? 32'd1 : (k >= 15) ? 32'd2 : 32'd0);
         end else begin
            checkVal($sformatf("stall end ser[%0d]", k), 32'(ser_out), 32'd1);
            checkVal($sformatf("stall end busy[%0d]", k), 32'(busy), 32'd0);
            checkVal($sformatf("stall done[%0d]", k), 32'(done), (k == 21) ? 32'd1 : 32'd0);
         end
         step = ((k + 1) % 3 == 0);
      end
      step = 1'b1;

      // Ignore while busy: second request and input changes mid-frame
      ignSer = 9'b0_0011_101_1;
      len   = 4'd3;
      data  = 15'h0005;
      start = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         tick();
         start = (i >= 2 && i <= 5);
         if (i >= 2) begin
            len  = 4'd15;
            data = 15'h0000;
         end
         checkVal($sformatf("ignore ser[%0d]", i), 32'(ser_out), 32'(ignSer[8 - i]));
         checkVal($sformatf("ignore done[%0d]", i), 32'(done), (i == 8) ? 32'd1 : 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checkVal($sformatf("ignore no second frame ser[%0d]", i), 32'(ser_out), 32'd1);
         checkVal($sformatf("ignore no second frame busy[%0d]", i), 32'(busy), 32'd0);
      end

      // Back-to-back: start held high, len=1, data=1
      b2bSer = 7'b0_0001_1_1;
      len   = 4'd1;
      data  = 15'h0001;
      start = 1'b1;
      for (int k = 0; k < 21; k++) begin
         tick();
         checkVal($sformatf("b2b ser[%0d]", k), 32'(ser_out), 32'(b2bSer[6 - k % 7]));
         checkVal($sformatf("b2b done[%0d]", k), 32'(done), (k % 7 == 6) ? 32'd1 : 32'd0);
         checkVal($sformatf("b2b busy[%0d]", k), 32'(busy), (k % 7 == 6) ? 32'd0 : 32'd1);
      end
      start = 1'b0;
      tick();
      tick();
      tick();
      tick();
      tick();
      tick();
      tick();
      checkVal("b2b drained", 32'(busy), 32'd0);

      // Reset during LEN, asserted between clock edges
      len   = 4'd15;
      data  = 15'h7FFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      checkVal("pre-reset busy", 32'(busy), 32'd1);
      #1 rst = 1'b0;
      #1;
      checkVal("async reset ser", 32'(ser_out), 32'd1);
      checkVal("async reset busy", 32'(busy), 32'd0);
      checkVal("async reset done", 32'(done), 32'd0);
      checkVal("async reset rem", 32'(remaining), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      checkVal("post-reset line", 32'(ser_out), 32'd1);
      // len=2 (0010), data ..01
      runFrame("after reset", 4'd2, 15'h7FFD, 20'b0_0010_01, 7);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
